// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies used by both the control shell and the arithmetic core.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_MUL_LAT = 5;
  localparam int DEFAULT_DIV_LAT = 10;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between an issuing pipeline and the multiply/divide unit.
// op stays a raw 3-bit field so undefined codes can be presented and ignored.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit_arith.sv
// Purely combinational MULT/MULTU/DIV/DIVU datapath working on captured operands;
// wr drops when the op produces no architectural result (divide by zero, non-arith op).
module mdu_arith
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             wr,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] sa, sb, sprod;
  logic        [2*WIDTH-1:0] uprod;
  logic        [WIDTH-1:0]   b_safe, uquot, urem;
  logic signed [WIDTH-1:0]   squot, srem;
  logic                      b_zero;

  assign sa    = {{WIDTH{a[WIDTH-1]}}, a};
  assign sb    = {{WIDTH{b[WIDTH-1]}}, b};
  assign sprod = sa * sb;
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Substitute a harmless divisor so the dividers never see zero; wr masks the result.
  assign b_zero = (b == '0);
  assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign squot  = $signed(a) / $signed(b_safe);
  assign srem   = $signed(a) % $signed(b_safe);
  assign uquot  = a / b_safe;
  assign urem   = a % b_safe;

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    wr = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      MDU_MULT: begin
        wr = 1'b1;
        hi = sprod[2*WIDTH-1:WIDTH];
        lo = sprod[WIDTH-1:0];
      end
      MDU_MULTU: begin
        wr = 1'b1;
        hi = uprod[2*WIDTH-1:WIDTH];
        lo = uprod[WIDTH-1:0];
      end
      MDU_DIV: begin
        wr = !b_zero;
        if (a == MOST_NEG && b == '1) begin
          hi = '0;
          lo = MOST_NEG;
        end else begin
          hi = srem;
          lo = squot;
        end
      end
      MDU_DIVU: begin
        wr = !b_zero;
        hi = urem;
        lo = uquot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential shell of the multiply/divide unit: IDLE/RUN control with a latency
// down-counter, operand capture and the architectural HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MUL_LAT = DEFAULT_MUL_LAT,
  parameter int DIV_LAT = DEFAULT_DIV_LAT
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             busy_q;

  logic             res_wr;
  logic [WIDTH-1:0] res_hi, res_lo;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .wr (res_wr),
    .hi (res_hi),
    .lo (res_lo)
  );

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= MDU_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                op_q   <= bus.op;
                a_q    <= bus.a;
                b_q    <= bus.b;
                cnt    <= (bus.op == MDU_MULT || bus.op == MDU_MULTU) ? MUL_CNT : DIV_CNT;
                busy_q <= 1'b1;
                state  <= ST_RUN;
              end
              MDU_MTHI: hi_q <= bus.a;
              MDU_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // start is deliberately not looked at here, including on the finishing edge.
          if (cnt == ONE) begin
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table of ops with hand-derived HI/LO and
// busy length through a scoreboard, plus sequences for ignored starts and reset abort.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the launch happens on the following rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic complete();
    int   n;
    exp_t e;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got completion with empty queue expected a pending entry");
    end else begin
      e = sb.pop_front();
      check($sformatf("%s.busy_cycles", e.name), n, e.cyc);
      check($sformatf("%s.hi", e.name), bus.hi, e.hi);
      check($sformatf("%s.lo", e.name), bus.lo, e.lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_t e;

    vecs.push_back(vec_t'{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_m2x3"});
    vecs.push_back(vec_t'{MDU_DIVU,  32'd17,       32'd5,        32'd2,        32'd3,        10, "divu_17_5"});
    vecs.push_back(vec_t'{MDU_DIV,   32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 10, "div_m17_5"});
    vecs.push_back(vec_t'{MDU_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0,  "mthi"});
    vecs.push_back(vec_t'{MDU_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0,  "mtlo"});
    vecs.push_back(vec_t'{MDU_NONE,  32'hDEADDEAD, 32'd1,        32'h00001234, 32'h00005678, 0,  "none"});
    vecs.push_back(vec_t'{3'd7,      32'hBEEFBEEF, 32'd1,        32'h00001234, 32'h00005678, 0,  "undef7"});
    vecs.push_back(vec_t'{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max"});
    vecs.push_back(vec_t'{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5,  "mult_m1m1"});
    vecs.push_back(vec_t'{MDU_MTLO,  32'd7,        32'd0,        32'h00000000, 32'd7,        0,  "mtlo7"});
    vecs.push_back(vec_t'{MDU_DIV,   32'd100,      32'd0,        32'h00000000, 32'd7,        10, "div_by0"});
    vecs.push_back(vec_t'{MDU_DIVU,  32'd100,      32'd0,        32'h00000000, 32'd7,        10, "divu_by0"});
    vecs.push_back(vec_t'{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf"});
    vecs.push_back(vec_t'{MDU_DIV,   32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 10, "div_17_m5"});
    vecs.push_back(vec_t'{MDU_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 10, "divu_max_16"});
    vecs.push_back(vec_t'{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  "mult_minsq"});
    vecs.push_back(vec_t'{MDU_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5,  "mult_7_m3"});

    bus.start = 1'b0;
    bus.op    = MDU_NONE;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.busy", {31'b0, bus.busy}, 32'd0);
    check("reset.hi", bus.hi, 32'd0);
    check("reset.lo", bus.lo, 32'd0);
    reset = 1'b0;

    // The first vector launches on the very first rising edge after release.
    foreach (vecs[i]) begin
      sb.push_back(exp_t'{vecs[i].hi, vecs[i].lo, vecs[i].cyc, vecs[i].name});
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      complete();
    end

    // MULTU in flight: MTLO on busy cycle 2, operand churn, MULT on the final busy cycle.
    sb.push_back(exp_t'{32'd0, 32'd21, 5, "multu_ignore"});
    issue(MDU_MULTU, 32'd3, 32'd7);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin
        bus.start = 1'b1;
        bus.op    = MDU_MTLO;
        bus.a     = 32'hDEAD0000;
      end else if (n == 3) begin
        bus.start = 1'b0;
        bus.a     = 32'd99;
        bus.b     = 32'd99;
        check("multu_ignore.lo_hold", bus.lo, 32'hFFFFFFEB);
      end else if (n == 5) begin
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check("multu_ignore.busy_cycles", n, e.cyc);
    check("multu_ignore.hi", bus.hi, e.hi);
    check("multu_ignore.lo", bus.lo, e.lo);
    @(negedge clk);
    check("multu_ignore.no_relaunch", {31'b0, bus.busy}, 32'd0);
    check("multu_ignore.lo_after", bus.lo, 32'd21);

    // Reset asserted on busy cycle 3 of a DIV clears everything at once and nothing lands later.
    issue(MDU_DIV, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_abort.busy", {31'b0, bus.busy}, 32'd0);
    check("rst_abort.hi", bus.hi, 32'd0);
    check("rst_abort.lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_after.busy", {31'b0, bus.busy}, 32'd0);
    check("rst_after.hi", bus.hi, 32'd0);
    check("rst_after.lo", bus.lo, 32'd0);

    sb.push_back(exp_t'{32'd0, 32'd42, 5, "post_rst_multu"});
    issue(MDU_MULTU, 32'd6, 32'd7);
    complete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width.
REQ-002 Parameter MUL_LAT, default 5: cycles busy for MULT/MULTU, minimum 1.
REQ-003 Parameter DIV_LAT, default 10: cycles busy for DIV/DIVU, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 start  input  1  single-cycle pulse; launches the operation on op.
REQ-007 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE.
REQ-008 a  input  WIDTH  operand A; dividend for DIV/DIVU; source for MTHI/MTLO.
REQ-009 b  input  WIDTH  operand B; divisor for DIV/DIVU.
REQ-010 busy  output  1  high while a multiply/divide is in flight.
REQ-011 hi  output  WIDTH  HI register, registered.
REQ-012 lo  output  WIDTH  LO register, registered.

Function
REQ-013 States: IDLE and RUN only; a down-counter holds the remaining cycles of the current operation.
REQ-014 IDLE, start=1, op=MULT/MULTU/DIV/DIVU: a, b and op captured; counter loaded with MUL_LAT or DIV_LAT; busy=1 from the next cycle.
REQ-015 RUN: counter decrements each cycle; at the cycle counter reaches 1, next edge writes hi/lo, busy=0, state returns to IDLE.
REQ-016 Total latency: busy high exactly MUL_LAT (or DIV_LAT) cycles; new hi/lo visible on the first cycle busy is low.
REQ-017 hi/lo hold their old values throughout RUN; no partial results visible.
REQ-018 MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-019 MULTU: same as MULT with both operands unsigned.
REQ-020 DIV: signed, quotient truncated toward zero into lo, remainder (sign of dividend) into hi.
REQ-021 DIVU: unsigned quotient into lo, remainder into hi.
REQ-022 Divisor zero (DIV or DIVU): operation runs full DIV_LAT, hi and lo left unchanged.
REQ-023 DIV with a = most-negative value and b = -1: lo = most-negative value, hi = 0.
REQ-024 MTHI/MTLO with start=1 in IDLE: hi (or lo) = a on next edge; busy stays 0.
REQ-025 start=1 while busy=1 (any op): ignored, in-flight operation unaffected.
REQ-026 start=1 with op=NONE or an undefined code: no state change.
REQ-027 start=1 in the same cycle the in-flight operation completes: ignored; upstream relaunches when busy=0.
REQ-028 Operands captured at launch; a/b changes during RUN have no effect.

Reset
REQ-029 reset=1 asynchronously forces state IDLE, counter 0, busy=0, hi=0, lo=0.
REQ-030 reset asserted mid-operation aborts it; no result written after reset releases.
REQ-031 First start honoured on the first rising edge with reset low.

Structure
REQ-032 Shared package holds op encodings (MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and default latency constants; the control decoder uses the same package.
REQ-033 Result computed from captured operands by a single combinational arithmetic sub-module, mdu_arith; the sequential shell owns counter, state and HI/LO.

Verification
REQ-034 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 DIVU a=17, b=5 -> busy high 10 cycles, then lo=3, hi=2; DIV a=-17, b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
REQ-036 MTHI a=0x1234 then MTLO a=0x5678, back-to-back -> hi=0x1234, lo=0x5678, busy never high.
REQ-037 DIV b=0 after MTLO 7 -> busy 10 cycles, lo stays 7; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-038 MULTU launched, MTLO and second MULT issued on cycles 2 and 5 of busy -> both ignored, result of first MULTU only.
REQ-039 reset pulsed on cycle 3 of a DIV -> busy, hi, lo = 0 immediately, remain 0 after release with no start.
